// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared format codes, opcodes and FSM state for the instruction encoder
package instr_encoder_pkg;

    // Same encoding as the decoder's ImmSrc select
    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_U = 2'b11;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef enum logic {
        IDLE = 1'b0,
        LO   = 1'b1
    } state_t;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32I I/S/B/U word packer with immediate range check
import instr_encoder_pkg::*;

module instr_pack (
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic fits12;
    logic fits13;

    // Signed fit: every bit above the field's sign bit must copy that sign bit
    assign fits12 = (imm[31:11] == {21{imm[11]}});
    assign fits13 = (imm[31:12] == {20{imm[12]}});

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = fits12;
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = fits12;
            end
            FMT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = fits13 && !imm[0];
            end
            default: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields into RV32I words, expands LI, emits addressed words
import instr_encoder_pkg::*;

module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic              li,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_count
);

    state_t      state, next_state;
    logic [31:0] pack_word;
    logic        pack_legal;
    logic [31:0] lo_instr;
    logic        out_free;
    logic        accept;
    logic        li_short;
    logic [19:0] li_hi;
    logic        load;
    logic [31:0] load_word;
    logic        lo_load;
    logic        err_set;

    instr_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .imm    (imm),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign li_short = (imm[31:11] == {21{imm[11]}});
    // ADDI sign-extends its 12-bit immediate, so round the upper part up when lo is negative
    assign li_hi    = imm[31:12] + {19'd0, imm[11]};

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_word  = '0;
        lo_load    = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (li) begin
                        load = 1'b1;
                        if (li_short) begin
                            load_word = {imm[11:0], 5'd0, 3'b000, rd, OPC_OPIMM};
                        end else begin
                            load_word  = {li_hi, rd, OPC_LUI};
                            lo_load    = 1'b1;
                            next_state = LO;
                        end
                    end else if (pack_legal) begin
                        load      = 1'b1;
                        load_word = pack_word;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            LO: begin
                if (out_free) begin
                    load       = 1'b1;
                    load_word  = lo_instr;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= ADDR_W'(BASE_ADDR);
            lo_instr  <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            // out_addr names the word in the register, so it advances as that word leaves
            if (out_valid && out_ready) begin
                out_addr <= out_addr + 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_instr <= load_word;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (lo_load) begin
                lo_instr <= {imm[11:0], rd, 3'b000, rd, OPC_OPIMM};
            end
            err <= err_set;
            if (err_set && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator. Takes instruction fields plus a 32-bit immediate and packs them into RV32I instruction words for the I, S, B and U formats.
- Also expands the LI pseudo-instruction into LUI+ADDI.
- Feeds the instruction-memory loader, which writes the words sequentially.
- Has a valid/ready input and a registered valid/ready output that carries a word address.

Parameters:
- ADDR_W, 8, width of the output word-address counter.
- BASE_ADDR, 0, address counter value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- fmt  in  2  immediate format, same code as the decoder's ImmSrc: 00 I, 01 S, 10 B, 11 U.
- li  in  1  1 = LI pseudo-op; fmt, opcode, funct3, rs1 and rs2 are ignored.
- opcode  in  7  instr[6:0].
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  instr[14:12].
- imm  in  32  immediate value, already sign-extended.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_instr.
- err  out  1  one-cycle pulse: the request was rejected.
- err_count  out  8  number of rejected requests, saturating.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_count=0. FSM state is IDLE.
- Output is a single register stage. in_ready = (state==IDLE) && (!out_valid || out_ready). Latency from accept to out_valid is 1 cycle.
- Holding: out_instr and out_addr stay stable while out_valid && !out_ready.
- Address: out_addr increments by 1 on every output handshake and wraps modulo 2^ADDR_W.
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
- Range check at accept (li=0). The request is legal only if:
  - I and S: imm[31:11] is all-equal.
  - B: imm[0]=0 and imm[31:12] is all-equal.
  - U: imm[11:0]=0.
- Illegal request: it is consumed (the handshake completes), nothing is emitted, err pulses in the next cycle, and err_count increments, saturating at 255.
- LI, when imm[31:11] is all-equal: emit one word, ADDI rd,x0,imm[11:0] (opcode 0010011, funct3 000). Stay in IDLE.
- LI otherwise:
  - hi = imm[31:12] + imm[11], 20-bit, wrapping (mod 2^20); lo = imm[11:0].
  - Emit LUI rd,hi (opcode 0110111) and go to state LO.
  - In LO: in_ready=0. When the output register is free (!out_valid || out_ready), load ADDI rd,rd,lo and return to IDLE.
  - rd=0 follows the same rules; there is no special case.
- FSM: IDLE -> LO on an accepted two-word LI. LO -> IDLE when the ADDI word is loaded. No other transitions.
- Simultaneous events: a new word may load in the same cycle the previous one hands off, so back-to-back throughput is 1 word/cycle.
- Mid-operation reset: rst overrides everything. A pending LO word and the held output are discarded and out_addr returns to BASE_ADDR.

Decomposition:
- Shared package holds:
  - FMT_I/FMT_S/FMT_B/FMT_U 2-bit constants, identical to the decoder's ImmSrc codes.
  - OPC_LUI=0110111 and OPC_OPIMM=0010011.
  - A state enum {IDLE, LO}.
- One natural sub-module, instr_pack: combinational fmt+fields -> 32-bit word plus a legal flag. The top level holds the FSM, output register, counters and LI split.

Test Plan:
- fmt=S, rs1=2, rs2=5, f3=010, imm=0xFFFFFFFC, opcode 0100011 -> out_instr=0xFE512E23 at addr 0; feeding it through the decoder with ImmSrc=01 returns 0xFFFFFFFC.
- fmt=B, imm=0x00000801, then fmt=U, imm=0x12345678 -> no output words, two err pulses, err_count=2, out_addr unchanged.
- li=1, rd=10, imm=0x12345FFF -> LUI 0x12346537 at addr 0, then ADDI 0xFFF50513 at addr 1; a request offered during LO sees in_ready=0.
- li=1, rd=1, imm=0xFFFFF800 -> a single word, ADDI 0x80000093.
- Hold out_ready=0 for 5 cycles with a word pending -> out_instr and out_addr stay stable, in_ready=0; then stream 300 legal I-type words -> out_addr wraps 255->0 and 1 word/cycle is sustained.
- Assert rst while in LO -> the next cycle shows out_valid=0, out_addr=0, state IDLE, and the ADDI word is never emitted.
